// File: rtl/tick_bcd_counter.sv
// Four-digit BCD up/down counter advanced by rising edges of a slow tick input,
// with a time-multiplexed active-low 7-segment display. Everything runs on clk.
module tick_bcd_counter #(
  parameter int REFRESH_W = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick_in,
  input  logic        en,
  input  logic        up_dn,
  input  logic        clr,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        carry,
  output logic        load_err,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  // Two flops for metastability, the third only for edge detection.
  logic s1, s2, s3;
  logic tick_evt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick_evt = s2 & ~s3;

  logic [15:0] inc_val, dec_val;
  logic        inc_wrap, dec_wrap;
  logic        load_ok;

  // Ripple the carry/borrow through the digits; it survives to the end only on wrap.
  always_comb begin
    inc_val  = count;
    inc_wrap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (inc_wrap) begin
        if (count[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = count[4*i +: 4] + 4'd1;
          inc_wrap          = 1'b0;
        end
      end
    end
  end

  always_comb begin
    dec_val  = count;
    dec_wrap = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (dec_wrap) begin
        if (count[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = count[4*i +: 4] - 4'd1;
          dec_wrap          = 1'b0;
        end
      end
    end
  end

  assign load_ok = (load_val[3:0]   <= 4'd9) && (load_val[7:4]   <= 4'd9) &&
                   (load_val[11:8]  <= 4'd9) && (load_val[15:12] <= 4'd9);

  // clr beats load beats an enabled tick; losers are dropped, not deferred.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count    <= 16'h0000;
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      load_err <= 1'b0;
      if (clr) begin
        count <= 16'h0000;
      end else if (load) begin
        if (load_ok) count    <= load_val;
        else         load_err <= 1'b1;
      end else if (en && tick_evt) begin
        if (up_dn) begin
          count <= inc_val;
          carry <= inc_wrap;
        end else begin
          count <= dec_val;
          carry <= dec_wrap;
        end
      end
    end
  end

  logic [REFRESH_W-1:0] refresh;
  logic [1:0]           sel;
  logic [3:0]           digit;

  assign sel = refresh[REFRESH_W-1:REFRESH_W-2];

  always_comb begin
    case (sel)
      2'd0:    digit = count[3:0];
      2'd1:    digit = count[7:4];
      2'd2:    digit = count[11:8];
      default: digit = count[15:12];
    endcase
  end

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      refresh <= '0;
      an      <= 4'b1111;
      seg     <= 7'b1111111;
    end else begin
      refresh <= refresh + {{(REFRESH_W-1){1'b0}}, 1'b1};
      an      <= ~(4'b0001 << sel);
      seg     <= seg_decode(digit);
    end
  end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Bench for tick_bcd_counter: directed scenarios plus randomized traffic, all
// compared each cycle against a decimal-arithmetic model of the counter and display.
module tb_tick_bcd_counter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tick_in;
  logic        en;
  logic        up_dn;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic [15:0] count;
  logic        carry;
  logic        load_err;
  logic [6:0]  seg;
  logic [3:0]  an;

  int n_checks = 0;
  int n_errors = 0;

  tick_bcd_counter #(.REFRESH_W(4)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .tick_in  (tick_in),
    .en       (en),
    .up_dn    (up_dn),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .carry    (carry),
    .load_err (load_err),
    .seg      (seg),
    .an       (an)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  int         m_val;      // counter as a plain decimal 0..9999
  bit         m_carry, m_err;
  bit         hist [3];   // tick_in samples from the last three edges, [0] newest
  int         m_edges;    // clk edges since reset release
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [15:0] to_bcd(input int v);
    return 16'((v / 1000) % 10 << 12 | (v / 100) % 10 << 8 | (v / 10) % 10 << 4 | v % 10);
  endfunction

  function automatic int pow10(input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return p;
  endfunction

  // A rise first sampled two edges ago takes effect at this edge.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_val   <= 0;
      m_carry <= 1'b0;
      m_err   <= 1'b0;
      hist    <= '{1'b0, 1'b0, 1'b0};
      m_edges <= 0;
      m_an    <= 4'hF;
      m_seg   <= 7'h7F;
    end else begin
      automatic int  nv  = m_val;
      automatic bit  c   = 1'b0;
      automatic bit  e   = 1'b0;
      automatic bit  evt = hist[1] && !hist[2];
      automatic int  sel = (m_edges % 16) / 4;
      automatic bit  ok  = 1'b1;
      automatic int  lv  = 0;
      for (int i = 0; i < 4; i++) begin
        automatic int d = int'(load_val >> (4 * i)) & 15;
        if (d > 9) ok = 1'b0;
        lv = lv + d * pow10(i);
      end
      if (clr) nv = 0;
      else if (load) begin
        if (ok) nv = lv;
        else e = 1'b1;
      end else if (en && evt) begin
        if (up_dn) begin c = (m_val == 9999); nv = (m_val + 1) % 10000; end
        else       begin c = (m_val == 0);    nv = (m_val + 9999) % 10000; end
      end
      m_an    <= 4'hF ^ (4'h1 << sel);
      m_seg   <= seg_tab[(m_val / pow10(sel)) % 10];
      m_val   <= nv;
      m_carry <= c;
      m_err   <= e;
      hist    <= '{tick_in, hist[0], hist[1]};
      m_edges <= m_edges + 1;
    end
  end

  // ---------------- scoreboard ----------------
  bit chk_on = 1'b0;
  int carry_cnt = 0;
  int err_cnt = 0;

  always @(negedge clk) begin
    if (chk_on) begin
      check("count", count, to_bcd(m_val));
      check("carry", carry, m_carry);
      check("load_err", load_err, m_err);
      check("an", an, m_an);
      check("seg", seg, m_seg);
      if (carry) carry_cnt++;
      if (load_err) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick_pulse(input int w, input int g);
    @(negedge clk) tick_in = 1'b1;
    repeat (w) @(negedge clk);
    tick_in = 1'b0;
    repeat (g) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v);
    @(negedge clk) begin load = 1'b1; load_val = v; end
    @(negedge clk) load = 1'b0;
  endtask

  task automatic do_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [15:0] rand_load_val();
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 9) << 12 | $urandom_range(0, 9) << 8 |
               $urandom_range(0, 9) << 4 | $urandom_range(0, 9));
  endfunction

  task automatic random_op();
    automatic int r = $urandom_range(0, 9);
    en    = ($urandom_range(0, 4) != 0);
    up_dn = 1'($urandom_range(0, 1));
    if (r == 0)      do_clr();
    else if (r <= 2) do_load(rand_load_val());
    else             tick_pulse($urandom_range(1, 3), $urandom_range(1, 3));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0] prev_an;
    bit         found;

    rstn = 1'b0; tick_in = 1'b0; en = 1'b1; up_dn = 1'b1;
    clr = 1'b0; load = 1'b0; load_val = 16'h0000;
    repeat (2) @(negedge clk);
    check("rst_count", count, 16'h0000);
    check("rst_carry", carry, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    check("rst_an", an, 4'b1111);
    check("rst_seg", seg, 7'b1111111);
    rstn = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);
    check("first_an", an, 4'b1110);
    check("first_seg", seg, 7'b1000000);

    // update lands two edges after s1 first samples the rise
    @(negedge clk) tick_in = 1'b1;
    @(posedge clk) #1 check("lat_k", count, 16'h0000);
    @(posedge clk) #1 check("lat_k1", count, 16'h0000);
    @(posedge clk) #1 check("lat_k2", count, 16'h0001);
    @(negedge clk) tick_in = 1'b0;
    for (int i = 0; i < 11; i++) tick_pulse($urandom_range(1, 4), $urandom_range(1, 3));
    settle();
    check("up12", count, 16'h0012);
    check("up12_carry_pulses", carry_cnt, 0);

    // up wrap
    do_load(16'h9998);
    carry_cnt = 0;
    tick_pulse(1, 1); settle();
    check("up_9999", count, 16'h9999);
    tick_pulse(2, 1); settle();
    check("up_wrap", count, 16'h0000);
    check("up_wrap_carry_pulses", carry_cnt, 1);

    // down wrap and borrow
    up_dn = 1'b0;
    do_load(16'h0000);
    carry_cnt = 0;
    tick_pulse(1, 2); settle();
    check("dn_wrap", count, 16'h9999);
    check("dn_wrap_carry_pulses", carry_cnt, 1);
    do_load(16'h0200);
    tick_pulse(3, 1); settle();
    check("dn_borrow", count, 16'h0199);

    // rejected load, then clr overriding a bad load
    err_cnt = 0;
    do_load(16'h12A4); settle();
    check("bad_load_count", count, 16'h0199);
    check("bad_load_err_pulses", err_cnt, 1);
    err_cnt = 0;
    @(negedge clk) begin clr = 1'b1; load = 1'b1; load_val = 16'h12A4; end
    @(negedge clk) begin clr = 1'b0; load = 1'b0; end
    settle();
    check("clr_bad_load_count", count, 16'h0000);
    check("clr_bad_load_err_pulses", err_cnt, 0);

    // clr, load and tick event in the same cycle
    up_dn = 1'b1;
    do_load(16'h0042);
    carry_cnt = 0;
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk);
    @(negedge clk) begin clr = 1'b1; load = 1'b1; load_val = 16'h0555; end
    @(negedge clk) begin clr = 1'b0; load = 1'b0; tick_in = 1'b0; end
    settle();
    check("coincident_count", count, 16'h0000);
    check("coincident_carry_pulses", carry_cnt, 0);

    // disabled ticks
    do_load(16'h0777);
    en = 1'b0;
    repeat (5) tick_pulse($urandom_range(1, 3), $urandom_range(1, 3));
    settle();
    check("en0_count", count, 16'h0777);
    en = 1'b1;

    // tick_in held high across reset release gives exactly one tick
    @(negedge clk) tick_in = 1'b1;
    #2 rstn = 1'b0;
    @(negedge clk) rstn = 1'b1;
    repeat (8) @(negedge clk);
    tick_in = 1'b0;
    settle();
    check("held_tick_count", count, 16'h0001);

    // randomized traffic against the model
    for (int i = 0; i < 200; i++) random_op();
    en = 1'b1; up_dn = 1'b1;
    settle();

    // display scan of 1234
    do_load(16'h1234);
    prev_an = an;
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (prev_an == 4'b0111 && an == 4'b1110) found = 1'b1;
      prev_an = an;
    end
    check("scan_sync", found, 1'b1);
    check("scan_an0", an, 4'b1110);
    check("scan_seg0", seg, 7'b0011001);
    repeat (4) @(negedge clk);
    check("scan_an1", an, 4'b1101);
    check("scan_seg1", seg, 7'b0110000);
    repeat (4) @(negedge clk);
    check("scan_an2", an, 4'b1011);
    check("scan_seg2", seg, 7'b0100100);
    repeat (4) @(negedge clk);
    check("scan_an3", an, 4'b0111);
    check("scan_seg3", seg, 7'b1111001);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst_count", count, 16'h0000);
    check("async_rst_an", an, 4'b1111);
    check("async_rst_seg", seg, 7'b1111111);
    check("async_rst_carry", carry, 1'b0);
    @(negedge clk) rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
